// File: rtl/cla_seq_adder_pkg.sv
// Shared ALU definitions for the nibble-serial adder: op and state encodings,
// nibble width, and the operand-latch helpers.
package cla_seq_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Subtraction is performed as A + ~B + carry.
  function automatic logic op_is_sub(op_e op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  function automatic logic init_carry(op_e op, logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      OP_ADC:  return cin;
      default: return ~cin;
    endcase
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Request/response bundle for the nibble-serial adder.
interface cla_seq_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [1:0]       i_op;
  logic             i_cin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_carry;
  logic             o_overflow;
  logic             o_zero;

  modport master (
    output i_valid, i_a, i_b, i_op, i_cin, i_ready,
    input  o_ready, o_valid, o_result, o_carry, o_overflow, o_zero
  );

  modport slave (
    input  i_valid, i_a, i_b, i_op, i_cin, i_ready,
    output o_ready, o_valid, o_result, o_carry, o_overflow, o_zero
  );
endinterface

// File: rtl/cla_seq_adder_cla_4bit.sv
// Existing 4-bit carry-lookahead adder; purely combinational.
module cla_4bit
  import cla_seq_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum_c,
  output logic             cout_c
);
  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum_c  = p ^ c[NIB_W-1:0];
  assign cout_c = c[NIB_W];
endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit add/sub engine that reuses one 4-bit CLA, one nibble per cycle,
// LSB first, with carry/overflow/zero flags and valid/ready on both sides.
module cla_seq_adder
  import cla_seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic             i_clk,
  input logic             i_rst_n,
  cla_seq_adder_if.slave  bus
);
  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned CNT_W = $clog2(NIB);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             ready_q;
  logic             valid_q;
  logic             carry_f;
  logic             ovf_f;
  logic             zero_f;

  op_e              op_c;
  logic             accept_c;
  logic             last_c;
  logic [NIB_W-1:0] a_nib_c;
  logic [NIB_W-1:0] b_nib_c;
  logic [NIB_W-1:0] sum_c;
  logic             cout_c;
  logic [WIDTH-1:0] res_nxt_c;

  assign op_c     = op_e'(bus.i_op);
  assign accept_c = (state == ST_IDLE) && ready_q && bus.i_valid;
  assign last_c   = (cnt == CNT_W'(NIB - 1));
  assign a_nib_c  = a_q[{cnt, 2'b00} +: NIB_W];
  assign b_nib_c  = b_q[{cnt, 2'b00} +: NIB_W];

  cla_4bit u_cla (
    .a      (a_nib_c),
    .b      (b_nib_c),
    .cin    (carry_q),
    .sum_c  (sum_c),
    .cout_c (cout_c)
  );

  // Result with the current nibble merged in, so flags see the final value.
  always_comb begin
    res_nxt_c = res_q;
    res_nxt_c[{cnt, 2'b00} +: NIB_W] = sum_c;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      carry_f <= 1'b0;
      ovf_f   <= 1'b0;
      zero_f  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            a_q     <= bus.i_a;
            b_q     <= op_is_sub(op_c) ? ~bus.i_b : bus.i_b;
            carry_q <= init_carry(op_c, bus.i_cin);
            cnt     <= '0;
            ready_q <= 1'b0;
            state   <= ST_RUN;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          res_q   <= res_nxt_c;
          carry_q <= cout_c;
          if (last_c) begin
            cnt     <= '0;
            carry_f <= cout_c;
            ovf_f   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_nxt_c[WIDTH-1] != a_q[WIDTH-1]);
            zero_f  <= ~|res_nxt_c;
            valid_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_result   = res_q;
  assign bus.o_carry    = carry_f;
  assign bus.o_overflow = ovf_f;
  assign bus.o_zero     = zero_f;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder at WIDTH=32: directed arithmetic cases,
// backpressure, mid-operation reset and randomized back-to-back traffic.
module tb_cla_seq_adder;
  import cla_seq_adder_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             z;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             cin;
    res_t             exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  res_t sb[$];

  cla_seq_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic [WIDTH-1:0] a, b, input op_e op, input logic cin,
                              input logic [WIDTH-1:0] r, input logic c, v, z);
    vec_t t;
    t.a = a; t.b = b; t.op = op; t.cin = cin;
    t.exp = {r, c, v, z};
    return t;
  endfunction

  // Full-width reference; overflow from exact signed arithmetic.
  function automatic res_t model(input logic [WIDTH-1:0] a, b, input op_e op, input logic cin);
    logic           sub;
    logic           ci;
    logic [WIDTH:0] s;
    longint         ta, tb, tr;
    res_t           r;
    sub = (op == OP_SUB) || (op == OP_SBB);
    case (op)
      OP_ADD:  ci = 1'b0;
      OP_SUB:  ci = 1'b1;
      OP_ADC:  ci = cin;
      default: ci = ~cin;
    endcase
    s  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (WIDTH+1)'(ci);
    ta = longint'($signed(a));
    tb = longint'($signed(b));
    tr = sub ? (ta - tb - longint'(!ci)) : (ta + tb + longint'(ci));
    r.r = s[WIDTH-1:0];
    r.c = s[WIDTH];
    r.v = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
    r.z = (s[WIDTH-1:0] == '0);
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (bus.o_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Drives one request, scrambles inputs after accept, waits for o_valid.
  task automatic issue(input vec_t t, output int acc_cyc, output int lat);
    wait_ready();
    bus.i_a = t.a; bus.i_b = t.b; bus.i_op = t.op; bus.i_cin = t.cin;
    bus.i_valid = 1'b1;
    sb.push_back(t.exp);
    acc_cyc = cyc;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_a = ~t.a; bus.i_b = ~t.b; bus.i_cin = ~t.cin;
    lat = 0;
    while (bus.o_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic collect(output res_t act, output res_t exp);
    act = {bus.o_result, bus.o_carry, bus.o_overflow, bus.o_zero};
    exp = sb.pop_front();
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_ready, bus.o_valid, bus.o_result, bus.o_carry, bus.o_overflow, bus.o_zero} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ready=%b valid=%b r=%h c=%b v=%b z=%b want all 0",
               bus.o_ready, bus.o_valid, bus.o_result, bus.o_carry, bus.o_overflow, bus.o_zero);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b want 0", bus.o_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_first_edge: got ready=%b valid=%b want ready=1 valid=0", bus.o_ready, bus.o_valid);
    end
  endtask

  task automatic test_add();
    vec_t t[3];
    int   lat, acc;
    res_t act, exp;
    t[0] = mk(32'h0000_0001, 32'hFFFF_FFFF, OP_ADD, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    t[1] = mk(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    t[2] = mk(32'h0000_0001, 32'h0000_0001, OP_ADD, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    foreach (t[i]) begin
      issue(t[i], acc, lat);
      checks++;
      if (lat != NIB) begin
        errors++;
        $display("FAIL add[%0d] latency: got %0d want %0d", i, lat, NIB);
      end
      collect(act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL add[%0d]: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                 i, act.r, act.c, act.v, act.z, exp.r, exp.c, exp.v, exp.z);
      end
    end
  endtask

  task automatic test_sub();
    vec_t t[3];
    int   lat, acc;
    res_t act, exp;
    t[0] = mk(32'h8000_0000, 32'h0000_0001, OP_SUB, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    t[1] = mk(32'h0000_0005, 32'h0000_0007, OP_SUB, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    t[2] = mk(32'h0000_0005, 32'h0000_0005, OP_SUB, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    foreach (t[i]) begin
      issue(t[i], acc, lat);
      checks++;
      if (lat != NIB) begin
        errors++;
        $display("FAIL sub[%0d] latency: got %0d want %0d", i, lat, NIB);
      end
      collect(act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL sub[%0d]: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                 i, act.r, act.c, act.v, act.z, exp.r, exp.c, exp.v, exp.z);
      end
    end
  endtask

  task automatic test_carry_in();
    vec_t t[3];
    int   lat, acc;
    res_t act, exp;
    t[0] = mk(32'h0000_000F, 32'h0000_0000, OP_ADC, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    t[1] = mk(32'h0000_0010, 32'h0000_000F, OP_SBB, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    t[2] = mk(32'h0000_0010, 32'h0000_000F, OP_SBB, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    foreach (t[i]) begin
      issue(t[i], acc, lat);
      collect(act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL carry_in[%0d]: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                 i, act.r, act.c, act.v, act.z, exp.r, exp.c, exp.v, exp.z);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t act, exp;
    int   n;
    logic saw_valid;
    wait_ready();
    bus.i_a = 32'h0000_0003; bus.i_b = 32'h0000_0004; bus.i_op = OP_ADD; bus.i_cin = 1'b0;
    bus.i_valid = 1'b1;
    sb.push_back({32'h0000_0007, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    bus.i_a = 32'hDEAD_BEEF; bus.i_b = 32'h0000_0001; bus.i_op = OP_SUB;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b0 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_run_busy: got ready=%b valid=%b want 0 0", bus.o_ready, bus.o_valid);
    end
    bus.i_valid = 1'b0;
    n = 2;
    while (bus.o_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != NIB) begin
      errors++;
      $display("FAIL bp_latency: got %0d want %0d", n, NIB);
    end
    exp = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      act = {bus.o_result, bus.o_carry, bus.o_overflow, bus.o_zero};
      checks++;
      if (act !== exp || bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got r=%h c=%b v=%b z=%b valid=%b ready=%b want r=%h c=%b v=%b z=%b valid=1 ready=0",
                 k, act.r, act.c, act.v, act.z, bus.o_valid, bus.o_ready, exp.r, exp.c, exp.v, exp.z);
      end
      bus.i_valid = 1'b1;
      bus.i_a = $urandom; bus.i_b = $urandom;
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_handoff: got ready=%b valid=%b want ready=1 valid=0", bus.o_ready, bus.o_valid);
    end
    saw_valid = 1'b0;
    repeat (NIB + 2) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_queue: got o_valid=1 after ignored pulses want 0");
    end
  endtask

  task automatic test_reset_mid_run();
    vec_t t;
    int   lat, acc;
    res_t act, exp;
    logic saw_valid;
    wait_ready();
    bus.i_a = 32'h1234_5678; bus.i_b = 32'h1111_1111; bus.i_op = OP_ADD; bus.i_cin = 1'b0;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_ready, bus.o_valid, bus.o_result, bus.o_carry, bus.o_overflow, bus.o_zero} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: got ready=%b valid=%b r=%h c=%b v=%b z=%b want all 0",
               bus.o_ready, bus.o_valid, bus.o_result, bus.o_carry, bus.o_overflow, bus.o_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_ready: got %b want 1", bus.o_ready);
    end
    saw_valid = 1'b0;
    repeat (NIB + 2) begin
      if (bus.o_valid === 1'b1) saw_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_valid: got o_valid=1 for aborted op want 0");
    end
    t = mk(32'h1234_5678, 32'h1111_1111, OP_ADD, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    issue(t, acc, lat);
    collect(act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL midrun_after: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
               act.r, act.c, act.v, act.z, exp.r, exp.c, exp.v, exp.z);
    end
  endtask

  task automatic test_back_to_back();
    vec_t t;
    int   lat, acc, prev_acc;
    res_t act, exp;
    prev_acc = -1;
    for (int i = 0; i < 12; i++) begin
      t.a   = $urandom;
      t.b   = (i % 4 == 0) ? ~t.a : $urandom;
      t.op  = op_e'(2'($urandom_range(0, 3)));
      t.cin = 1'($urandom_range(0, 1));
      t.exp = model(t.a, t.b, t.op, t.cin);
      issue(t, acc, lat);
      checks++;
      if (lat != NIB) begin
        errors++;
        $display("FAIL b2b[%0d] latency: got %0d want %0d", i, lat, NIB);
      end
      if (prev_acc >= 0) begin
        checks++;
        if (acc - prev_acc != NIB + 2) begin
          errors++;
          $display("FAIL b2b[%0d] interval: got %0d want %0d", i, acc - prev_acc, NIB + 2);
        end
      end
      prev_acc = acc;
      collect(act, exp);
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h cin=%b: got r=%h c=%b v=%b z=%b want r=%h c=%b v=%b z=%b",
                 i, t.op, t.a, t.b, t.cin, act.r, act.c, act.v, act.z, exp.r, exp.c, exp.v, exp.z);
      end
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_op    = 2'b00;
    bus.i_cin   = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_carry_in();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
